uart_rx_core: RTL and testbench

- Synthesizable UART receiver inside the SoC, on the io_uart_rx side of the serial link.
- Deserializes 8N1 frames driven by the bench UART transceiver or a host, and presents each received byte on a ready/valid interface to the SoC fabric.
- Flags framing errors and overruns.

---
 rtl/uart_rx_core.sv | 177 +++++++++++++++++
 tb/tb_uart_rx_core.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_core
//  Purpose  : 8N1 UART receiver. The serial line is synchronised with two
//             flops, framed by a mid-bit sampling FSM, and every good byte is
//             presented on a ready/valid interface. Bad stop bits and bytes
//             dropped because the previous byte was not yet taken are
//             reported as single-cycle pulses.
//  Ports    : i_clock         - system clock, rising edge
//             i_reset         - asynchronous reset, active low
//             i_uart_rx       - serial line, idles high, asynchronous
//             o_data          - received byte, held while valid is pending
//             o_data_valid    - byte available
//             i_data_ready    - consumer takes the byte when high with valid
//             o_framing_error - one-cycle pulse on a low stop bit
//             o_overrun       - one-cycle pulse when a finished byte is lost
//             o_busy          - FSM is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_core #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_uart_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_data_valid,
    input  logic                 i_data_ready,
    output logic                 o_framing_error,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W        = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] c_full_bit = CNT_W'(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] c_half_bit = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [BIT_W-1:0] c_last_bit = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] c_bit_one  = BIT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t                 state_q;
    logic                   sync1_q;
    logic                   rx_s_q;
    logic [CNT_W-1:0]       clk_cnt_q;
    logic [BIT_W-1:0]       bit_cnt_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   valid_q;
    logic                   fe_q;
    logic                   ovr_q;
    logic                   w_tick;

    // Two-flop synchroniser; reset high so a reset never looks like a start bit.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= i_uart_rx;
            rx_s_q  <= sync1_q;
        end
    end

    // A counter loaded with N expires N cycles later, in the cycle it reads 1.
    assign w_tick = (clk_cnt_q == c_cnt_one);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            fe_q  <= 1'b0;
            ovr_q <= 1'b0;

            // Acceptance clears valid; a commit below in the same cycle wins.
            if (valid_q && i_data_ready) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_q   <= S_START;
                        bit_cnt_q <= '0;
                        clk_cnt_q <= c_half_bit;
                    end
                end

                S_START: begin
                    if (w_tick) begin
                        if (rx_s_q) begin
                            // Line went back high before mid start bit: glitch.
                            state_q <= S_IDLE;
                        end else begin
                            state_q   <= S_DATA;
                            clk_cnt_q <= c_full_bit;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q - c_cnt_one;
                    end
                end

                S_DATA: begin
                    if (w_tick) begin
                        shift_q   <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                        clk_cnt_q <= c_full_bit;
                        if (bit_cnt_q == c_last_bit) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + c_bit_one;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q - c_cnt_one;
                    end
                end

                S_STOP: begin
                    if (w_tick) begin
                        if (rx_s_q) begin
                            // Slot is free if empty or being emptied this cycle.
                            if (!valid_q || i_data_ready) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                ovr_q <= 1'b1;
                            end
                            state_q <= S_IDLE;
                        end else begin
                            fe_q    <= 1'b1;
                            state_q <= S_WAIT_IDLE;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q - c_cnt_one;
                    end
                end

                S_WAIT_IDLE: begin
                    // A held-low line (break) must not be taken as a new start bit.
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_data          = data_q;
    assign o_data_valid    = valid_q;
    assign o_framing_error = fe_q;
    assign o_overrun       = ovr_q;
    assign o_busy          = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_uart_rx_core
//  Purpose  : Self-checking bench for uart_rx_core at 10 clocks per bit.
//             Frames are bit-banged onto the line; a negedge monitor records
//             accepted bytes and pulse activity, and results are compared
//             against the byte stream expected from what was sent.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

    localparam int CPB = 10;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       fe;
    logic       ovr;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    uart_rx_core #(
        .CLOCK_FREQ(1_000_000),
        .BAUD_RATE (100_000),
        .DATA_BITS (8)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_uart_rx      (rx),
        .o_data         (data),
        .o_data_valid   (valid),
        .i_data_ready   (ready),
        .o_framing_error(fe),
        .o_overrun      (ovr),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ monitor
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int   rise_cnt, fe_cnt, ovr_cnt, busy_cnt, stab_err;
    int   last_rise_cyc, ovr_cyc, cur_w, last_w;
    logic valid_prev = 1'b0;
    logic ready_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;

    always @(negedge clk) begin
        if (valid && !valid_prev) begin
            rise_cnt++;
            last_rise_cyc = cyc;
        end
        if (valid) cur_w++;
        if (!valid && valid_prev) begin
            last_w = cur_w;
            cur_w  = 0;
        end
        if (valid && ready) got_q.push_back(data);
        if (valid_prev && !ready_prev && valid && (data != data_prev)) stab_err++;
        if (fe) fe_cnt++;
        if (ovr) begin
            ovr_cnt++;
            ovr_cyc = cyc;
        end
        if (busy) busy_cnt++;
        valid_prev = valid;
        ready_prev = ready;
        data_prev  = data;
    end

    // ------------------------------------------------------------ helpers
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        got_q.delete();
        exp_q.delete();
        rise_cnt = 0; fe_cnt = 0; ovr_cnt = 0; busy_cnt = 0; stab_err = 0;
        last_rise_cyc = 0; ovr_cyc = 0; cur_w = 0; last_w = 0;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Returns the cycle number at which the start bit was put on the line.
    task automatic send_frame(input logic [7:0] b, input logic stop, output int fall);
        fall = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    // Pulses ready for one cycle each time valid appears.
    task automatic consume(input int n);
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            while (!valid && t < 400) begin
                @(posedge clk);
                #1;
                t++;
            end
            check_eq("consume_wait", (t < 400), 1);
            ready = 1'b1;
            @(posedge clk);
            #1;
            ready = 1'b0;
        end
    endtask

    task automatic check_stream(input string tag);
        check_eq({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq({tag, "_byte"}, got_q[i], exp_q[i]);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        int f, f2, gap;
        logic [7:0] b;
        logic [7:0] part;

        clr_mon();
        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_data",  data,  0);
        check_eq("rst_valid", valid, 0);
        check_eq("rst_fe",    fe,    0);
        check_eq("rst_ovr",   ovr,   0);
        check_eq("rst_busy",  busy,  0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(5);

        // Single frame 0xA5, always ready: valid 2+5+90+1 cycles after the edge.
        clr_mon();
        ready = 1'b1;
        send_frame(8'hA5, 1'b1, f);
        exp_q.push_back(8'hA5);
        idle(20);
        check_stream("single");
        check_eq("single_latency", last_rise_cyc - f, 98);
        check_eq("single_width",   last_w, 1);
        check_eq("single_rises",   rise_cnt, 1);
        check_eq("single_fe",      fe_cnt, 0);
        check_eq("single_ovr",     ovr_cnt, 0);

        // Back-to-back 0x00 0xFF 0x55 with a consumer that only pulses ready.
        clr_mon();
        ready = 1'b0;
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h55);
        fork
            begin
                send_frame(8'h00, 1'b1, f);
                send_frame(8'hFF, 1'b1, f);
                send_frame(8'h55, 1'b1, f);
            end
            consume(3);
        join
        idle(10);
        check_stream("b2b");
        check_eq("b2b_ovr", ovr_cnt, 0);
        check_eq("b2b_fe",  fe_cnt, 0);

        // Overrun: second byte dropped while first is still pending.
        clr_mon();
        ready = 1'b0;
        send_frame(8'h11, 1'b1, f);
        idle(3);
        send_frame(8'h22, 1'b1, f2);
        idle(5);
        check_eq("ovr_valid", valid, 1);
        check_eq("ovr_data",  data, 8'h11);
        check_eq("ovr_count", ovr_cnt, 1);
        check_eq("ovr_time",  ovr_cyc - f2, 98);
        check_eq("ovr_stable", stab_err, 0);
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        idle(5);
        exp_q.push_back(8'h11);
        check_stream("ovr");
        check_eq("ovr_cleared", valid, 0);

        // Framing error followed by a held-low line, then a good frame.
        clr_mon();
        ready = 1'b1;
        send_frame(8'h3C, 1'b0, f);
        repeat (30) @(posedge clk);
        #1;
        check_eq("fe_wait_busy", busy, 1);
        idle(10);
        check_eq("fe_released_busy", busy, 0);
        check_eq("fe_count", fe_cnt, 1);
        check_eq("fe_no_valid", rise_cnt, 0);
        send_frame(8'h81, 1'b1, f);
        exp_q.push_back(8'h81);
        idle(20);
        check_stream("fe_next");

        // Glitch: line low at cycles k..k+2 reaches START at k+3 and is
        // rejected at the half-bit check at k+8, so busy is high 5 cycles.
        clr_mon();
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(25);
        check_eq("glitch_busy_cycles", busy_cnt, 5);
        check_eq("glitch_no_valid",    rise_cnt, 0);
        check_eq("glitch_no_fe",       fe_cnt, 0);

        // Reset during bit 4 with a byte still pending.
        clr_mon();
        ready = 1'b0;
        send_frame(8'h5A, 1'b1, f);
        idle(5);
        check_eq("mid_pending", valid, 1);
        part = 8'h3C;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(part[i]);
        rx = part[4];
        repeat (5) @(posedge clk);
        #1;
        check_eq("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_data",  data,  0);
        check_eq("mid_rst_valid", valid, 0);
        check_eq("mid_rst_busy",  busy,  0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);
        clr_mon();
        ready = 1'b1;
        send_frame(8'h7E, 1'b1, f);
        exp_q.push_back(8'h7E);
        idle(20);
        check_stream("after_rst");

        // Random bytes with random idle gaps (including none), always ready.
        clr_mon();
        ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            b   = 8'($urandom);
            gap = $urandom_range(0, 12);
            send_frame(b, 1'b1, f);
            exp_q.push_back(b);
            if (gap > 0) idle(gap);
        end
        idle(20);
        check_stream("rand");
        check_eq("rand_ovr", ovr_cnt, 0);
        check_eq("rand_fe",  fe_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
